// File: rtl/ptw_responder.sv
// Page-table walker shared by the imem and dmem TLBs: round-robin request
// arbitration, multi-level walk through one PTE read port, one-cycle response.
module ptw_responder #(
    parameter int VPN_W  = 20,
    parameter int PPN_W  = 32,
    parameter int LEVELS = 2,
    parameter int IDX_W  = VPN_W / LEVELS,
    parameter int ADDR_W = PPN_W + IDX_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PPN_W-1:0]  io_ptbr,
    input  logic              io_imem_ptw_req_valid,
    output logic              io_imem_ptw_req_ready,
    input  logic [VPN_W-1:0]  io_imem_ptw_req_bits_vpn,
    input  logic              io_dmem_ptw_req_valid,
    output logic              io_dmem_ptw_req_ready,
    input  logic [VPN_W-1:0]  io_dmem_ptw_req_bits_vpn,
    output logic              io_imem_ptw_resp_valid,
    output logic              io_imem_ptw_resp_bits_error,
    output logic [PPN_W-1:0]  io_imem_ptw_resp_bits_ppn,
    output logic              io_dmem_ptw_resp_valid,
    output logic              io_dmem_ptw_resp_bits_error,
    output logic [PPN_W-1:0]  io_dmem_ptw_resp_bits_ppn,
    output logic              io_mem_req_valid,
    input  logic              io_mem_req_ready,
    output logic [ADDR_W-1:0] io_mem_req_bits_addr,
    input  logic              io_mem_resp_valid,
    input  logic [63:0]       io_mem_resp_bits_data
);
    // state | meaning
    // IDLE  | arbitrate between clients, accept one request
    // REQ   | PTE read presented to memory, held until accepted
    // WAIT  | waiting for PTE data, then descend or finish
    // RESP  | one-cycle response pulse to the latched client
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LEVELS - 1);

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             prio_q, prio_d;
    logic             client_q, client_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PPN_W-1:0] cur_ppn_q, cur_ppn_d;
    logic             err_q, err_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;

    logic             grant_imem;
    logic             grant_dmem;
    logic [VPN_W-1:0] vpn_shift;
    logic [IDX_W-1:0] idx;
    logic             pte_v;
    logic             pte_l;
    logic [PPN_W-1:0] pte_ppn;

    // Left-align the current level's index so it is always the top IDX_W bits.
    assign vpn_shift = vpn_q << (level_q * IDX_W);
    assign idx       = vpn_shift[VPN_W-1 -: IDX_W];
    assign pte_v     = io_mem_resp_bits_data[0];
    assign pte_l     = io_mem_resp_bits_data[1];
    assign pte_ppn   = PPN_W'(io_mem_resp_bits_data[63:32]);

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        prio_d    = prio_q;
        client_d  = client_q;
        vpn_d     = vpn_q;
        cur_ppn_d = cur_ppn_q;
        err_d     = err_q;
        ppn_d     = ppn_q;

        grant_imem = 1'b0;
        grant_dmem = 1'b0;

        io_imem_ptw_req_ready       = 1'b0;
        io_dmem_ptw_req_ready       = 1'b0;
        io_imem_ptw_resp_valid      = 1'b0;
        io_imem_ptw_resp_bits_error = 1'b0;
        io_imem_ptw_resp_bits_ppn   = '0;
        io_dmem_ptw_resp_valid      = 1'b0;
        io_dmem_ptw_resp_bits_error = 1'b0;
        io_dmem_ptw_resp_bits_ppn   = '0;
        io_mem_req_valid            = 1'b0;
        io_mem_req_bits_addr        = '0;

        unique case (state_q)
            IDLE: begin
                // prio_q = 0 favours imem, 1 favours dmem; flips only on contention.
                grant_imem = io_imem_ptw_req_valid && (!io_dmem_ptw_req_valid || !prio_q);
                grant_dmem = io_dmem_ptw_req_valid && !grant_imem;
                io_imem_ptw_req_ready = grant_imem;
                io_dmem_ptw_req_ready = grant_dmem;
                if (grant_imem || grant_dmem) begin
                    vpn_d     = grant_imem ? io_imem_ptw_req_bits_vpn : io_dmem_ptw_req_bits_vpn;
                    client_d  = grant_dmem;
                    cur_ppn_d = io_ptbr;
                    level_d   = '0;
                    err_d     = 1'b0;
                    ppn_d     = '0;
                    state_d   = REQ;
                    if (io_imem_ptw_req_valid && io_dmem_ptw_req_valid) begin
                        prio_d = ~prio_q;
                    end
                end
            end
            REQ: begin
                io_mem_req_valid     = 1'b1;
                io_mem_req_bits_addr = {cur_ppn_q, idx, 3'b000};
                if (io_mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (io_mem_resp_valid) begin
                    if (!pte_v) begin
                        err_d   = 1'b1;
                        ppn_d   = '0;
                        state_d = RESP;
                    end else if (pte_l) begin
                        err_d   = 1'b0;
                        ppn_d   = pte_ppn;
                        state_d = RESP;
                    end else if (level_q != LAST_LVL) begin
                        cur_ppn_d = pte_ppn;
                        level_d   = level_q + LVL_W'(1);
                        state_d   = REQ;
                    end else begin
                        err_d   = 1'b1;
                        ppn_d   = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                io_imem_ptw_resp_valid      = !client_q;
                io_imem_ptw_resp_bits_error = !client_q && err_q;
                io_imem_ptw_resp_bits_ppn   = client_q ? '0 : ppn_q;
                io_dmem_ptw_resp_valid      = client_q;
                io_dmem_ptw_resp_bits_error = client_q && err_q;
                io_dmem_ptw_resp_bits_ppn   = client_q ? ppn_q : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            level_q   <= '0;
            prio_q    <= 1'b0;
            client_q  <= 1'b0;
            vpn_q     <= '0;
            cur_ppn_q <= '0;
            err_q     <= 1'b0;
            ppn_q     <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            prio_q    <= prio_d;
            client_q  <= client_d;
            vpn_q     <= vpn_d;
            cur_ppn_q <= cur_ppn_d;
            err_q     <= err_d;
            ppn_q     <= ppn_d;
        end
    end

endmodule

// File: tb/tb_ptw_responder.sv
// Scoreboard bench for ptw_responder: directed walks against a PTE memory model.
`timescale 1ns/1ps
module tb_ptw_responder;
    localparam int VPN_W  = 20;
    localparam int PPN_W  = 32;
    localparam int IDX_W  = 10;
    localparam int ADDR_W = PPN_W + IDX_W + 3;

    typedef struct packed {
        logic             client;
        logic             err;
        logic [PPN_W-1:0] ppn;
    } resp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [PPN_W-1:0]  io_ptbr;
    logic              imem_valid, dmem_valid;
    logic [VPN_W-1:0]  imem_vpn, dmem_vpn;
    wire               imem_ready, dmem_ready;
    wire               imem_resp_valid, dmem_resp_valid;
    wire               imem_err, dmem_err;
    wire [PPN_W-1:0]   imem_ppn, dmem_ppn;
    wire               mem_req_valid;
    logic              mem_req_ready;
    wire [ADDR_W-1:0]  mem_req_addr;
    logic              mem_resp_valid;
    logic [63:0]       mem_resp_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int resp_seen = 0;
    int last_resp_cyc = 0;
    int stall_left = 0;
    bit hold_resp = 0;
    bit have_pend = 0;
    logic [ADDR_W-1:0] pend_addr;

    logic [VPN_W-1:0]  imem_q[$];
    logic [VPN_W-1:0]  dmem_q[$];
    resp_t             exp_resp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [63:0]       pte_mem [logic [ADDR_W-1:0]];

    ptw_responder dut (
        .clk                         (clk),
        .reset                       (reset),
        .io_ptbr                     (io_ptbr),
        .io_imem_ptw_req_valid       (imem_valid),
        .io_imem_ptw_req_ready       (imem_ready),
        .io_imem_ptw_req_bits_vpn    (imem_vpn),
        .io_dmem_ptw_req_valid       (dmem_valid),
        .io_dmem_ptw_req_ready       (dmem_ready),
        .io_dmem_ptw_req_bits_vpn    (dmem_vpn),
        .io_imem_ptw_resp_valid      (imem_resp_valid),
        .io_imem_ptw_resp_bits_error (imem_err),
        .io_imem_ptw_resp_bits_ppn   (imem_ppn),
        .io_dmem_ptw_resp_valid      (dmem_resp_valid),
        .io_dmem_ptw_resp_bits_error (dmem_err),
        .io_dmem_ptw_resp_bits_ppn   (dmem_ppn),
        .io_mem_req_valid            (mem_req_valid),
        .io_mem_req_ready            (mem_req_ready),
        .io_mem_req_bits_addr        (mem_req_addr),
        .io_mem_resp_valid           (mem_resp_valid),
        .io_mem_resp_bits_data       (mem_resp_data)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [63:0] pte(input bit v, input bit l, input logic [31:0] p);
        return {p, 30'b0, l, v};
    endfunction

    function automatic logic [ADDR_W-1:0] adr(input logic [PPN_W-1:0] p, input logic [IDX_W-1:0] i);
        return {p, i, 3'b000};
    endfunction

    function automatic resp_t mk(input bit c, input bit e, input logic [PPN_W-1:0] p);
        resp_t r;
        r.client = c;
        r.err    = e;
        r.ppn    = p;
        return r;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Client drivers: raise valid, hold until ready, drop after the accepting edge.
    task automatic client_proc(input bit c);
        logic [VPN_W-1:0] v;
        int waited;
        forever begin
            @(negedge clk);
            if ((c ? dmem_q.size() : imem_q.size()) > 0) begin
                if (c) begin
                    v = dmem_q.pop_front();
                    dmem_vpn = v;
                    dmem_valid = 1'b1;
                end else begin
                    v = imem_q.pop_front();
                    imem_vpn = v;
                    imem_valid = 1'b1;
                end
                waited = 0;
                #1;
                while (!(c ? dmem_ready : imem_ready) && waited < 1000) begin
                    @(negedge clk);
                    #1;
                    waited++;
                end
                if (waited >= 1000) chk(1'b0, "req_ready_timeout", 64'(c), 64'(v));
                @(negedge clk);
                if (c) dmem_valid = 1'b0;
                else   imem_valid = 1'b0;
            end
        end
    endtask

    initial client_proc(1'b0);
    initial client_proc(1'b1);

    // Memory model: optional stall, response one cycle after acceptance.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
            if (have_pend && !hold_resp) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = pte_mem.exists(pend_addr) ? pte_mem[pend_addr] : 64'h0;
                have_pend = 0;
            end
            if (stall_left > 0 && mem_req_valid) begin
                mem_req_ready = 1'b0;
                stall_left--;
                chk(exp_addr_q.size() > 0 && mem_req_addr == exp_addr_q[0], "stall_addr",
                    64'(mem_req_addr), exp_addr_q.size() > 0 ? 64'(exp_addr_q[0]) : 64'h0);
            end else begin
                mem_req_ready = 1'b1;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (exp_addr_q.size() == 0) begin
                    chk(1'b0, "mem_addr_unexpected", 64'(mem_req_addr), 64'h0);
                end else begin
                    chk(mem_req_addr == exp_addr_q[0], "mem_addr", 64'(mem_req_addr), 64'(exp_addr_q[0]));
                    void'(exp_addr_q.pop_front());
                end
                have_pend = 1;
                pend_addr = mem_req_addr;
            end
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    initial forever begin
        resp_t got;
        resp_t want;
        @(negedge clk);
        if (imem_resp_valid || dmem_resp_valid) begin
            resp_seen++;
            last_resp_cyc = cyc;
            got = dmem_resp_valid ? mk(1'b1, dmem_err, dmem_ppn) : mk(1'b0, imem_err, imem_ppn);
            if (imem_resp_valid && dmem_resp_valid) begin
                chk(1'b0, "resp_both_clients", 64'(got), 64'h0);
            end else if (exp_resp_q.size() == 0) begin
                chk(1'b0, "resp_unexpected", 64'(got), 64'h0);
            end else begin
                want = exp_resp_q.pop_front();
                chk(got == want, "resp", 64'(got), 64'(want));
            end
        end else begin
            chk(!imem_err && !dmem_err && imem_ppn == '0 && dmem_ppn == '0, "resp_bits_idle",
                {30'b0, imem_err, dmem_err, imem_ppn}, 64'h0);
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_resp_q.size() != 0 || exp_addr_q.size() != 0 || imem_q.size() != 0 ||
                dmem_q.size() != 0 || imem_valid || dmem_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(exp_resp_q.size() == 0 && exp_addr_q.size() == 0, {tag, "_drain"},
            {32'(exp_resp_q.size()), 32'(exp_addr_q.size())}, 64'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int t0;
        int seen0;
        int n;
        reset = 1'b0;
        io_ptbr = '0;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        imem_vpn = '0;
        dmem_vpn = '0;

        pte_mem[adr(32'h100, 10'h048)] = pte(1, 1, 32'hABCDE);
        pte_mem[adr(32'h300, 10'h003)] = pte(1, 0, 32'h200);
        pte_mem[adr(32'h200, 10'h007)] = pte(1, 1, 32'h55);
        pte_mem[adr(32'h400, 10'h001)] = pte(0, 1, 32'h777);
        pte_mem[adr(32'h500, 10'h002)] = pte(1, 0, 32'h600);
        pte_mem[adr(32'h600, 10'h002)] = pte(1, 0, 32'h999);
        pte_mem[adr(32'h700, 10'h028)] = pte(1, 1, 32'h1234);
        pte_mem[adr(32'h100, 10'h001)] = pte(1, 1, 32'h11);
        pte_mem[adr(32'h100, 10'h002)] = pte(1, 1, 32'h22);
        pte_mem[adr(32'h100, 10'h003)] = pte(1, 1, 32'h33);

        repeat (2) @(negedge clk);
        #1;
        chk(!imem_ready && !dmem_ready && !mem_req_valid && mem_req_addr == '0 &&
            !imem_resp_valid && !dmem_resp_valid, "reset_outputs",
            {58'b0, imem_ready, dmem_ready, mem_req_valid, imem_resp_valid, dmem_resp_valid, |mem_req_addr}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // single-level leaf on imem, minimum latency
        io_ptbr = 32'h100;
        @(posedge clk); #1;
        t0 = cyc;
        exp_addr_q.push_back(adr(32'h100, 10'h048));
        exp_resp_q.push_back(mk(1'b0, 1'b0, 32'hABCDE));
        imem_q.push_back(20'h12345);
        wait_done("leaf");
        chk(last_resp_cyc - t0 == 3, "lat_single", 64'(last_resp_cyc - t0), 64'd3);

        // two-level walk on dmem
        io_ptbr = 32'h300;
        @(posedge clk); #1;
        exp_addr_q.push_back(adr(32'h300, 10'h003));
        exp_addr_q.push_back(adr(32'h200, 10'h007));
        exp_resp_q.push_back(mk(1'b1, 1'b0, 32'h55));
        dmem_q.push_back(20'h00C07);
        wait_done("two_level");

        // invalid PTE at level 0
        io_ptbr = 32'h400;
        @(posedge clk); #1;
        exp_addr_q.push_back(adr(32'h400, 10'h001));
        exp_resp_q.push_back(mk(1'b0, 1'b1, 32'h0));
        imem_q.push_back(20'h00401);
        wait_done("fault_v0");

        // non-leaf at last level
        io_ptbr = 32'h500;
        @(posedge clk); #1;
        exp_addr_q.push_back(adr(32'h500, 10'h002));
        exp_addr_q.push_back(adr(32'h600, 10'h002));
        exp_resp_q.push_back(mk(1'b1, 1'b1, 32'h0));
        dmem_q.push_back(20'h00802);
        wait_done("fault_nonleaf");

        // memory backpressure for 5 cycles
        io_ptbr = 32'h700;
        @(posedge clk); #1;
        stall_left = 5;
        exp_addr_q.push_back(adr(32'h700, 10'h028));
        exp_resp_q.push_back(mk(1'b0, 1'b0, 32'h1234));
        imem_q.push_back(20'h0A3FF);
        wait_done("backpressure");
        chk(stall_left == 0, "stall_consumed", 64'(stall_left), 64'h0);

        // reset while waiting for PTE data; late response must be ignored
        io_ptbr = 32'h100;
        @(posedge clk); #1;
        hold_resp = 1;
        exp_addr_q.push_back(adr(32'h100, 10'h048));
        imem_q.push_back(20'h12345);
        n = 0;
        while (!have_pend && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(have_pend, "reach_wait", 64'(have_pend), 64'h1);
        seen0 = resp_seen;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk(!mem_req_valid && !imem_resp_valid && !dmem_resp_valid, "reset_mid_walk",
            {61'b0, mem_req_valid, imem_resp_valid, dmem_resp_valid}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        hold_resp = 0;
        repeat (8) @(negedge clk);
        chk(resp_seen == seen0, "no_resp_after_reset", 64'(resp_seen - seen0), 64'h0);
        chk(!have_pend, "late_mem_resp_sent", 64'(have_pend), 64'h0);
        io_ptbr = 32'h300;
        @(posedge clk); #1;
        exp_addr_q.push_back(adr(32'h300, 10'h003));
        exp_addr_q.push_back(adr(32'h200, 10'h007));
        exp_resp_q.push_back(mk(1'b1, 1'b0, 32'h55));
        dmem_q.push_back(20'h00C07);
        wait_done("after_reset");

        // round-robin: both valid from reset, three contended grants
        pulse_reset();
        io_ptbr = 32'h100;
        @(posedge clk); #1;
        exp_addr_q.push_back(adr(32'h100, 10'h048));
        exp_addr_q.push_back(adr(32'h100, 10'h001));
        exp_addr_q.push_back(adr(32'h100, 10'h002));
        exp_addr_q.push_back(adr(32'h100, 10'h003));
        exp_resp_q.push_back(mk(1'b0, 1'b0, 32'hABCDE));
        exp_resp_q.push_back(mk(1'b1, 1'b0, 32'h11));
        exp_resp_q.push_back(mk(1'b0, 1'b0, 32'h22));
        exp_resp_q.push_back(mk(1'b1, 1'b0, 32'h33));
        imem_q.push_back(20'h12345);
        imem_q.push_back(20'h00800);
        dmem_q.push_back(20'h00400);
        dmem_q.push_back(20'h00C00);
        wait_done("arbitration");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
